// File: rtl/rf_pkg.sv
// Shared definitions for the register-file instruction sequencer: opcode
// encodings, FSM state encoding, default datapath widths and small opcode
// classification helpers.
package rf_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 1;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OUT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Opcodes whose result is written back to rd.
  function automatic logic op_writes(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // 110 and 111 are the only undefined encodings.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_OUT;
  endfunction

endpackage

// File: rtl/rf_alu.sv
// Combinational datapath for the sequencer.
// Ports:
//   op    - instruction opcode
//   a     - rd operand (register file read-1 data)
//   b     - rs operand (register file read-2 data)
//   imm   - immediate field
//   y     - result (imm for LDI, b for MOV, a+b / a-b, a for OUT)
//   carry - carry out of ADD, borrow of SUB; 0 otherwise
module rf_alu
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  // One extra bit so the top bit is the carry of an add and the borrow of a
  // subtract (the subtraction wraps negative exactly when a < b).
  logic [DATA_W:0] wide;

  always_comb begin
    y     = '0;
    carry = 1'b0;
    wide  = '0;
    case (op)
      OP_LDI: y = imm;
      OP_MOV: y = b;
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = wide[DATA_W];
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = wide[DATA_W];
      end
      OP_OUT: y = a;
      default: ;
    endcase
  end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Instruction sequencer owning a 2-entry register file. Accepts one
// instruction over valid/ready, then runs a fixed accept/execute/writeback
// sequence (one instruction per three cycles).
//
// state  | meaning
// S_IDLE | ready for an instruction; latch it on instr_valid
// S_EXEC | register file read with rd/rs; result, carry, out_data registered
// S_WB   | write back (LDI/MOV/ADD/SUB), OUT pulse, or flag illegal; done=1
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   instr_valid/instr_ready - instruction handshake
//   instr                   - {op[2:0], rd, imm}; rs is imm[ADDR_W-1:0]
//   rf_en, rf_addr1, rf_addr2, rf_wdata - register file control
//   rf_rdata1, rf_rdata2    - register file combinational read data
//   out_valid, out_data     - OUT result pulse / held value
//   carry                   - carry/borrow of last ADD/SUB
//   err                     - sticky illegal-opcode flag
//   done                    - one-cycle retire pulse
module rf_seq_ctrl
  import rf_pkg::*;
#(
  parameter  int DATA_W  = RF_DATA_W,
  parameter  int ADDR_W  = RF_ADDR_W,
  localparam int INSTR_W = 3 + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               rf_en,
  output logic [ADDR_W-1:0]  rf_addr1,
  output logic [ADDR_W-1:0]  rf_addr2,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               carry,
  output logic               err,
  output logic               done
);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                carry_q;
  logic                err_q;

  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   rs_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_c;

  assign op_q  = instr_q[INSTR_W-1 -: 3];
  assign rd_q  = instr_q[DATA_W +: ADDR_W];
  assign imm_q = instr_q[DATA_W-1:0];
  // rs shares the low bits of the immediate field.
  assign rs_q  = instr_q[ADDR_W-1:0];

  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op_q),
    .a     (rf_rdata1),
    .b     (rf_rdata2),
    .imm   (imm_q),
    .y     (alu_y),
    .carry (alu_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      result_q   <= '0;
      out_data_q <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (instr_valid) instr_q <= instr;
        S_EXEC: begin
          result_q <= alu_y;
          if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= alu_c;
          // out_data is registered here so it is already valid during the
          // WB pulse and then holds until the next OUT.
          if (op_q == OP_OUT) out_data_q <= alu_y;
        end
        S_WB: if (!op_legal(op_q)) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_en       = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        rf_en     = op_writes(op_q);
        out_valid = (op_q == OP_OUT);
        done      = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rf_addr1 = rd_q;
  assign rf_addr2 = rs_q;
  assign rf_wdata = result_q;
  assign out_data = out_data_q;
  assign carry    = carry_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl with a behavioural 2x8 register file. A
// transaction-level model predicts every output each cycle; directed tests
// add literal expectations.
module tb_rf_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic        instr_ready;
  logic        rf_en;
  logic [0:0]  rf_addr1, rf_addr2;
  logic [7:0]  rf_wdata, rf_rdata1, rf_rdata2;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        carry, err, done;

  always #5 clk = ~clk;

  rf_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_en       (rf_en),
    .rf_addr1    (rf_addr1),
    .rf_addr2    (rf_addr2),
    .rf_wdata    (rf_wdata),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .carry       (carry),
    .err         (err),
    .done        (done)
  );

  // Register file: no reset, combinational reads, write on rising edge.
  logic [7:0] rf_mem [2] = '{8'h00, 8'h00};
  assign rf_rdata1 = rf_mem[rf_addr1];
  assign rf_rdata2 = rf_mem[rf_addr2];
  always @(posedge clk) if (rf_en) rf_mem[rf_addr1] <= rf_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: age = cycles since acceptance (0 idle, 1 execute, 2 writeback).
  int         age = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         acc_q[$];
  logic [2:0] m_op;
  logic       m_rd, m_rs;
  logic [7:0] m_res;
  logic       m_cnew;
  logic       m_carry = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_out = 8'h00;
  logic [7:0] m_rf [2] = '{8'h00, 8'h00};
  int         a_i, b_i, s_i;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      age = 0; m_carry = 1'b0; m_err = 1'b0; m_out = 8'h00;
      chk("rst_addr1", 32'(rf_addr1), 32'h0);
      chk("rst_addr2", 32'(rf_addr2), 32'h0);
      chk("rst_wdata", 32'(rf_wdata), 32'h0);
    end
    if (done === 1'b1) done_cnt++;
    chk("instr_ready", 32'(instr_ready), 32'(age == 0));
    chk("rf_en", 32'(rf_en), 32'(age == 2 && m_op inside {3'd1, 3'd2, 3'd3, 3'd4}));
    chk("done", 32'(done), 32'(age == 2));
    chk("out_valid", 32'(out_valid), 32'(age == 2 && m_op == 3'd5));
    chk("carry", 32'(carry), 32'(m_carry));
    chk("err", 32'(err), 32'(m_err));
    chk("out_data", 32'(out_data), 32'(m_out));
    chk("rf_mem0", 32'(rf_mem[0]), 32'(m_rf[0]));
    chk("rf_mem1", 32'(rf_mem[1]), 32'(m_rf[1]));
    if (age == 1) begin
      chk("exec_addr1", 32'(rf_addr1), 32'(m_rd));
      chk("exec_addr2", 32'(rf_addr2), 32'(m_rs));
    end
    if (age == 2 && m_op inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
      chk("wb_addr1", 32'(rf_addr1), 32'(m_rd));
      chk("wb_wdata", 32'(rf_wdata), 32'(m_res));
    end
    if (rst_n) begin
      case (age)
        0: if (instr_valid) begin
          m_op = instr[11:9]; m_rd = instr[8]; m_rs = instr[0];
          a_i = int'(m_rf[m_rd]); b_i = int'(m_rf[m_rs]);
          m_cnew = 1'b0; m_res = 8'h00;
          case (m_op)
            3'd1: m_res = instr[7:0];
            3'd2: m_res = 8'(b_i);
            3'd3: begin s_i = a_i + b_i; m_res = 8'(s_i % 256); m_cnew = (s_i > 255); end
            3'd4: begin s_i = a_i - b_i + 256; m_res = 8'(s_i % 256); m_cnew = (a_i < b_i); end
            3'd5: m_res = 8'(a_i);
            default: ;
          endcase
          acc_q.push_back(cyc);
          age = 1;
        end
        1: begin
          if (m_op == 3'd3 || m_op == 3'd4) m_carry = m_cnew;
          if (m_op == 3'd5) m_out = m_res;
          age = 2;
        end
        default: begin
          if (m_op inside {3'd1, 3'd2, 3'd3, 3'd4}) m_rf[m_rd] = m_res;
          if (m_op > 3'd5) m_err = 1'b1;
          age = 0;
        end
      endcase
    end
  end

  function automatic logic [11:0] mk(input logic [2:0] op, input logic rd, input logic [7:0] lo);
    return {op, rd, lo};
  endfunction

  // Present an instruction and return #1 after the edge that accepts it;
  // instr_valid is left high so back-to-back calls keep it asserted.
  task automatic send(input logic [11:0] ins);
    int n;
    n = 0;
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (instr_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=%0d required=<20", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic retire();
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int d0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ready", 32'(instr_ready), 32'h1);
    chk("reset_err", 32'(err), 32'h0);

    d0 = done_cnt;
    send(mk(3'b001, 1'b0, 8'h25)); retire();
    send(mk(3'b001, 1'b1, 8'h1A)); retire();
    chk("ldi_r0", 32'(rf_mem[0]), 32'h25);
    chk("ldi_r1", 32'(rf_mem[1]), 32'h1A);
    chk("ldi_done_pulses", 32'(done_cnt - d0), 32'd2);

    send(mk(3'b011, 1'b0, 8'h01)); retire();
    chk("add_r0", 32'(rf_mem[0]), 32'h3F);
    chk("add_carry", 32'(carry), 32'h0);

    send(mk(3'b100, 1'b1, 8'h00)); retire();
    chk("sub_r1", 32'(rf_mem[1]), 32'hDB);
    chk("sub_borrow", 32'(carry), 32'h1);

    send(mk(3'b101, 1'b1, 8'h00)); retire();
    chk("out_data_db", 32'(out_data), 32'hDB);
    chk("out_r1_kept", 32'(rf_mem[1]), 32'hDB);

    send(mk(3'b001, 1'b0, 8'hF0)); retire();
    send(mk(3'b011, 1'b0, 8'h00)); retire();
    chk("add_double_r0", 32'(rf_mem[0]), 32'hE0);
    chk("add_double_carry", 32'(carry), 32'h1);

    acc_q.delete();
    send(mk(3'b001, 1'b1, 8'h05));
    send(mk(3'b011, 1'b1, 8'h01));
    send(mk(3'b010, 1'b0, 8'h01));
    send(mk(3'b101, 1'b0, 8'h00));
    retire();
    if (acc_q.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk("queued_accept_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd3);
    end else begin
      checks++; errors++;
      $display("FAIL queued_accept_count actual=%0d required=4", acc_q.size());
    end
    chk("queued_r1", 32'(rf_mem[1]), 32'h0A);
    chk("queued_r0", 32'(rf_mem[0]), 32'h0A);
    chk("queued_out", 32'(out_data), 32'h0A);
    chk("carry_hold", 32'(carry), 32'h0);

    d0 = done_cnt;
    send(mk(3'b110, 1'b0, 8'h01)); retire();
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_done", 32'(done_cnt - d0), 32'd1);
    chk("illegal_r0_kept", 32'(rf_mem[0]), 32'h0A);
    send(mk(3'b001, 1'b1, 8'h33)); retire();
    chk("err_sticky", 32'(err), 32'h1);
    chk("post_err_ldi", 32'(rf_mem[1]), 32'h33);

    send(mk(3'b001, 1'b0, 8'h77));
    rst_n = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("async_rst_ready", 32'(instr_ready), 32'h1);
    chk("async_rst_rf_en", 32'(rf_en), 32'h0);
    chk("async_rst_err", 32'(err), 32'h0);
    chk("async_rst_out", 32'(out_data), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r0_kept", 32'(rf_mem[0]), 32'h0A);
    chk("rst_release_ready", 32'(instr_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/rf_seq_ctrl.md
Name: rf_seq_ctrl

Overview:
- Instruction sequencer that owns the 2-entry x 8-bit register file and drives its ports (enable, shared write/read-1 address, read-2 address, write data).
- Accepts one instruction at a time over a valid/ready handshake and decodes it.
- Runs a fixed 3-cycle accept/execute/writeback sequence with an internal add/subtract unit.
- Sits between the project's instruction source (testbench or fetch unit) and the register file; it is the file's only writer.

Parameters:
- DATA_W, 8, register/datapath width; must equal the register file width.
- ADDR_W, 1, register address width (2 registers).
- INSTR_W, 3+ADDR_W+DATA_W (12), instruction width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present; held stable until accepted
- instr_ready  out  1  controller idle, can accept
- instr  in  INSTR_W  instruction fields:
  - op = [INSTR_W-1 -: 3]
  - rd = [DATA_W +: ADDR_W]
  - imm = [DATA_W-1:0]
  - rs = [ADDR_W-1:0]
- rf_en  out  1  register file write enable
- rf_addr1  out  ADDR_W  register file write/read-1 address (= rd)
- rf_addr2  out  ADDR_W  register file read-2 address (= rs)
- rf_wdata  out  DATA_W  register file write data
- rf_rdata1  in  DATA_W  register file read-1 data (combinational)
- rf_rdata2  in  DATA_W  register file read-2 data (combinational)
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  DATA_W  OUT result
- carry  out  1  carry/borrow flag from last ADD/SUB
- err  out  1  sticky illegal-opcode flag
- done  out  1  one-cycle pulse, instruction retired

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0 except instr_ready=1; latched instruction and result register cleared.
  - An in-flight instruction is dropped; register file contents are untouched (the file has no reset).
- Opcodes:
  - 000 NOP
  - 001 LDI rd<=imm
  - 010 MOV rd<=rs
  - 011 ADD rd<=rd+rs
  - 100 SUB rd<=rd-rs
  - 101 OUT (out_data<=rd)
  - 110/111 illegal
- FSM IDLE -> EXEC -> WB -> IDLE, no other transitions.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready at edge T0, latch instr, go to EXEC. instr_valid without ready is ignored.
  - EXEC (T0..T1): instr_ready=0; rf_addr1=rd, rf_addr2=rs. Result computed from rf_rdata1/rf_rdata2/imm and registered at T1; carry updated at T1 for ADD/SUB only. Go to WB.
  - WB (T1..T2):
    - rf_en=1 only for LDI/MOV/ADD/SUB, with rf_wdata=result and rf_addr1=rd held; write lands at T2.
    - OUT: out_valid=1, out_data=rd value, no rf_en.
    - Illegal opcode: err set at T2, no write, no out_valid.
    - done=1 for every opcode, including illegal.
    - Go to IDLE at T2.
- Throughput: one instruction per 3 cycles. instr_ready returns high the cycle after T2, so the earliest next accept is edge T3.
- rf_en is low in every state except WB; it is never asserted in IDLE or EXEC.
- Arithmetic: ADD carry = bit DATA_W of the (DATA_W+1)-bit sum; SUB carry = borrow (rd<rs unsigned); results wrap modulo 2^DATA_W.
- rd==rs is legal: ADD doubles the register, SUB yields 0 with carry=0.
- carry holds its value across non-arithmetic instructions.
- err clears only on reset.
- out_data holds its value until the next OUT.
- Reset asserted in EXEC or WB: no write completes unless the T2 edge has already occurred.

Decomposition:
- Shared package rf_pkg holds:
  - opcode localparams (OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_OUT)
  - state encoding (S_IDLE, S_EXEC, S_WB)
  - DATA_W/ADDR_W defaults
- One natural sub-module: rf_alu (combinational ADD/SUB/pass-through with carry output), instantiated in rf_seq_ctrl.
- The bench instantiates rf_seq_ctrl with the existing register file.

Test Plan:
- Reset, then LDI r0,0x25 and LDI r1,0x1A -> rf_en high for exactly one cycle per instruction; r0=0x25, r1=0x1A; done pulses twice.
- ADD r0,r1 -> r0=0x3F, carry=0; then ADD r0,r0 with r0=0xF0 -> r0=0xE0, carry=1.
- SUB r1,r0 with r1=0x1A, r0=0x3F -> r1=0xDB, carry=1; then OUT r1 -> out_valid one cycle, out_data=0xDB, no rf_en.
- instr_valid held high with 4 queued instructions -> accepts at edges T0, T0+3, T0+6, T0+9; instr_ready low in EXEC/WB.
- Opcode 110 -> err=1 after WB, no rf_en, done pulses; err stays 1 through later legal instructions until rst_n=0.
- rst_n asserted during EXEC of LDI r0,0x77 -> outputs reset immediately, r0 keeps its old value, instr_ready=1 after release.
